// File: rtl/hough_vote_sched.sv
// Edge-pixel vote scheduler: tracks raster position, thresholds pixels, queues edge
// coordinates and issues NTHETA vote requests per edge over a valid/ready handshake.
module hough_vote_sched #(
  parameter int COLS    = 10,
  parameter int ROWS    = 10,
  parameter int NTHETA  = 4,
  parameter int THETA_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               Start,
  input  logic [7:0]         Threshold,
  input  logic [7:0]         Pixel,
  input  logic               Frame,
  input  logic               Line,
  output logic               VoteValid,
  input  logic               VoteReady,
  output logic [7:0]         VoteX,
  output logic [7:0]         VoteY,
  output logic [THETA_W-1:0] VoteTheta,
  output logic               Busy,
  output logic               FrameDone,
  output logic               Overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]         COL_LAST   = 8'(COLS - 1);
  localparam logic [7:0]         ROW_LAST   = 8'(ROWS - 1);
  localparam logic [THETA_W-1:0] THETA_LAST = THETA_W'(NTHETA - 1);
  localparam logic [AW:0]        CNT_FULL   = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [7:0]         thr_r;
  logic [7:0]         col_r, row_r, col_s, row_s;
  logic               classify_s, last_s, is_edge_s;
  logic               stg_valid_r;
  logic [7:0]         stg_col_r, stg_row_r;
  logic [15:0]        mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [AW:0]        cnt_r;
  logic               full_s, empty_s, push_s, pop_s, drop_s;
  logic               vote_valid_r;
  logic [7:0]         vote_x_r, vote_y_r;
  logic [THETA_W-1:0] vote_theta_r;
  logic               busy_r, done_r, ovf_r;

  assign VoteValid = vote_valid_r;
  assign VoteX     = vote_x_r;
  assign VoteY     = vote_y_r;
  assign VoteTheta = vote_theta_r;
  assign Busy      = busy_r;
  assign FrameDone = done_r;
  assign Overflow  = ovf_r;

  // Position of the current pixel and its edge classification
  always_comb begin
    col_s = col_r;
    row_s = row_r;
    if (Frame) begin
      col_s = 8'd0;
      row_s = 8'd0;
    end else if (Line) begin
      col_s = 8'd0;
      row_s = row_r + 8'd1;
    end else begin
      col_s = col_r + 8'd1;
      row_s = row_r;
    end
    classify_s = (state_r == RUN) || ((state_r == SYNC) && Frame);
    is_edge_s  = classify_s && (Pixel >= thr_r);
    last_s     = classify_s && (col_s == COL_LAST) && (row_s == ROW_LAST);
  end

  // FIFO flags and emitter pop; a pop frees room for a same-cycle push when full
  always_comb begin
    full_s  = (cnt_r == CNT_FULL);
    empty_s = (cnt_r == (AW + 1)'(0));
    pop_s   = !empty_s && (!vote_valid_r || (VoteReady && (vote_theta_r == THETA_LAST)));
    push_s  = stg_valid_r && (!full_s || pop_s);
    drop_s  = stg_valid_r && full_s && !pop_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:  if (Start) state_nxt_s = SYNC; else state_nxt_s = IDLE;
      SYNC:  if (last_s) state_nxt_s = DRAIN;
             else if (Frame) state_nxt_s = RUN;
             else state_nxt_s = SYNC;
      RUN:   if (last_s) state_nxt_s = DRAIN; else state_nxt_s = RUN;
      DRAIN: if (!stg_valid_r && empty_s && !vote_valid_r) state_nxt_s = DONE;
             else state_nxt_s = DRAIN;
      DONE:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, latched threshold, position counters and status outputs
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_r     <= IDLE;
      thr_r       <= 8'd0;
      col_r       <= 8'd0;
      row_r       <= 8'd0;
      stg_valid_r <= 1'b0;
      stg_col_r   <= 8'd0;
      stg_row_r   <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= (state_nxt_s == DONE);
      stg_valid_r <= is_edge_s;
      stg_col_r   <= col_s;
      stg_row_r   <= row_s;
      if (classify_s) begin
        col_r <= col_s;
        row_r <= row_s;
      end
      if ((state_r == IDLE) && Start) begin
        thr_r <= Threshold;
        ovf_r <= 1'b0;
      end else if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Edge-coordinate storage; contents are don't-care while the count is zero
  always_ff @(posedge Clk) begin
    if (push_s) mem_r[wr_ptr_r] <= {stg_col_r, stg_row_r};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      cnt_r    <= (AW + 1)'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + (AW + 1)'(1);
        2'b01:   cnt_r <= cnt_r - (AW + 1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Vote emitter: walks theta 0..NTHETA-1 for the working coordinate
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      vote_valid_r <= 1'b0;
      vote_x_r     <= 8'd0;
      vote_y_r     <= 8'd0;
      vote_theta_r <= THETA_W'(0);
    end else if (pop_s) begin
      {vote_x_r, vote_y_r} <= mem_r[rd_ptr_r];
      vote_theta_r         <= THETA_W'(0);
      vote_valid_r         <= 1'b1;
    end else if (vote_valid_r && VoteReady) begin
      if (vote_theta_r != THETA_LAST) vote_theta_r <= vote_theta_r + THETA_W'(1);
      else vote_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hough_vote_sched.sv
// Self-checking bench for hough_vote_sched: table-driven frame scenarios, hand-written
// Start/reset corner cases and randomized frames against a queue-based reference model.
module tb_hough_vote_sched;
  localparam int NTHETA = 4;
  localparam int DEPTH  = 2;

  logic       Clk = 1'b0;
  logic       nReset, Start, Frame, Line, VoteReady;
  logic [7:0] Threshold, Pixel, VoteX, VoteY;
  logic [3:0] VoteTheta;
  logic       VoteValid, Busy, FrameDone, Overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [23:0] dut_q[$];
  logic [23:0] exp_q[$];

  hough_vote_sched #(.COLS(10), .ROWS(10), .NTHETA(NTHETA), .THETA_W(4), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .Threshold(Threshold), .Pixel(Pixel),
    .Frame(Frame), .Line(Line), .VoteValid(VoteValid), .VoteReady(VoteReady),
    .VoteX(VoteX), .VoteY(VoteY), .VoteTheta(VoteTheta), .Busy(Busy),
    .FrameDone(FrameDone), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: record accepted votes, count FrameDone pulses, check stall stability
  bit prev_stall = 1'b0;
  logic [23:0] prev_vote;
  always @(negedge Clk) begin
    if (!nReset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, VoteValid}, 32'd1);
        check("stall_hold", {8'd0, VoteX, VoteY, 4'd0, VoteTheta}, {8'd0, prev_vote});
      end
      if (VoteValid && VoteReady) dut_q.push_back({VoteX, VoteY, 4'd0, VoteTheta});
      if (FrameDone) done_cnt++;
      prev_stall = VoteValid && !VoteReady;
      prev_vote  = {VoteX, VoteY, 4'd0, VoteTheta};
    end
  end

  // Reference model: one-cycle classify stage, bounded queue, current item + theta
  bit          model_on = 1'b0;
  bit          m_pend_v, m_cur_v, m_ovf;
  logic [15:0] m_pend_xy, m_cur_xy;
  int          m_cur_t;
  logic [15:0] m_q[$];

  task automatic model_reset();
    m_q.delete();
    m_pend_v = 1'b0; m_cur_v = 1'b0; m_ovf = 1'b0; m_cur_t = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit e, input logic [15:0] xy, input bit rdy);
    bit acc;
    acc = m_cur_v && rdy;
    if (acc) exp_q.push_back({m_cur_xy, 8'(m_cur_t)});
    if (!m_cur_v || (acc && m_cur_t == NTHETA - 1)) begin
      if (m_q.size() > 0) begin
        m_cur_xy = m_q.pop_front(); m_cur_t = 0; m_cur_v = 1'b1;
      end else begin
        m_cur_v = 1'b0;
      end
    end else if (acc) begin
      m_cur_t++;
    end
    if (m_pend_v) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_pend_xy);
      else m_ovf = 1'b1;
    end
    m_pend_v = e; m_pend_xy = xy;
  endtask

  task automatic tick(input logic st, input logic [7:0] thr, input logic [7:0] pix,
                      input logic frm, input logic ln, input logic rdy,
                      input bit medge, input logic [15:0] mxy);
    @(posedge Clk); #1;
    Start = st; Threshold = thr; Pixel = pix; Frame = frm; Line = ln; VoteReady = rdy;
    if (model_on) model_step(medge, mxy, rdy);
  endtask

  function automatic logic [7:0] std_pix(input int idx);
    case (idx)
      24: return 8'd178;
      25: return 8'd202;
      36: return 8'd190;
      69: return 8'd208;
      86: return 8'd185;
      96: return 8'd195;
      default: return 8'((idx * 7) % 170);
    endcase
  endfunction

  typedef struct packed {
    logic [7:0]       thr;
    logic [1:0]       mode;   // 0: ready=1, 1: toggling, 2: held low until frame end
    logic [2:0]       nedge;
    logic [4:0][15:0] edges;
    logic             ovf;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] thr, input logic [1:0] mode, input logic [2:0] n,
                              input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                              input logic [15:0] e3, input logic [15:0] e4, input logic ovf);
    vec_t v;
    v.thr = thr; v.mode = mode; v.nedge = n; v.ovf = ovf;
    v.edges[0] = e0; v.edges[1] = e1; v.edges[2] = e2; v.edges[3] = e3; v.edges[4] = e4;
    return v;
  endfunction

  task automatic expect_edges(input vec_t v);
    exp_q.delete();
    for (int e = 0; e < int'(v.nedge); e++)
      for (int t = 0; t < NTHETA; t++) exp_q.push_back({v.edges[e], 8'(t)});
  endtask

  task automatic compare_votes(input string tag);
    int n;
    check({tag, "_nvotes"}, dut_q.size(), exp_q.size());
    n = (dut_q.size() < exp_q.size()) ? dut_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_vote%0d", tag, i), {8'd0, dut_q[i]}, {8'd0, exp_q[i]});
  endtask

  task automatic wait_done(input string tag, input int start_cnt, input logic [7:0] thr, input int mode);
    for (int c = 0; c < 400 && done_cnt == start_cnt; c++)
      tick(1'b0, thr, 8'd0, 1'b0, 1'b0, (mode == 1) ? 1'(c % 2) : (mode == 3 ? 1'($urandom_range(0, 1)) : 1'b1), 1'b0, 16'd0);
    for (int c = 0; c < 3; c++) tick(1'b0, thr, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    check({tag, "_framedone"}, done_cnt - start_cnt, 32'd1);
    check({tag, "_busy_end"}, {31'd0, Busy}, 32'd0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int sc;
    logic r;
    dut_q.delete();
    sc = done_cnt;
    tick(1'b1, v.thr, 8'd0, 1'b0, 1'b0, v.mode == 2'd0, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) tick(1'b0, v.thr, 8'd255, 1'b0, 1'b0, v.mode == 2'd0, 1'b0, 16'd0);
    check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
    for (int idx = 0; idx < 100; idx++) begin
      r = (v.mode == 2'd0) ? 1'b1 : (v.mode == 2'd1) ? 1'(idx % 2) : 1'b0;
      tick(1'b0, v.thr, std_pix(idx), idx == 0, (idx % 10) == 0, r, 1'b0, 16'd0);
    end
    if (v.mode == 2'd2) begin
      tick(1'b0, v.thr, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      check({tag, "_ovf_pre"}, {31'd0, Overflow}, {31'd0, v.ovf});
      check({tag, "_work"}, {16'd0, VoteValid, VoteX[6:0], VoteY}, {16'd0, 1'b1, v.edges[0][14:8], v.edges[0][7:0]});
      check({tag, "_work_theta"}, {28'd0, VoteTheta}, 32'd0);
    end
    wait_done(tag, sc, v.thr, v.mode);
    check({tag, "_ovf"}, {31'd0, Overflow}, {31'd0, v.ovf});
    expect_edges(v);
    compare_votes(tag);
  endtask

  vec_t tbl[4];

  initial begin
    int sc;
    tbl[0] = mk(8'd200, 2'd0, 3'd2, 16'h0502, 16'h0906, 16'h0, 16'h0, 16'h0, 1'b0);
    tbl[1] = mk(8'd180, 2'd0, 3'd5, 16'h0502, 16'h0603, 16'h0906, 16'h0608, 16'h0609, 1'b0);
    tbl[2] = mk(8'd180, 2'd2, 3'd3, 16'h0502, 16'h0603, 16'h0906, 16'h0, 16'h0, 1'b1);
    tbl[3] = mk(8'd200, 2'd1, 3'd2, 16'h0502, 16'h0906, 16'h0, 16'h0, 16'h0, 1'b0);

    nReset = 1'b0; Start = 1'b0; Threshold = 8'd0; Pixel = 8'd0;
    Frame = 1'b0; Line = 1'b0; VoteReady = 1'b1;
    #1;
    check("rst_outputs", {8'd0, VoteValid, Busy, FrameDone, Overflow, VoteTheta, VoteX, VoteY}, 32'd0);
    repeat (3) @(posedge Clk);
    #1 nReset = 1'b1;

    for (int i = 0; i < 4; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // Start mid-frame arms the next Frame; a second Start inside RUN is ignored
    dut_q.delete();
    sc = done_cnt;
    for (int idx = 0; idx < 100; idx++)
      tick(idx == 50, 8'd200, std_pix(idx), idx == 0, (idx % 10) == 0, 1'b1, 1'b0, 16'd0);
    check("s5_busy_sync", {31'd0, Busy}, 32'd1);
    for (int idx = 0; idx < 100; idx++)
      tick(idx == 30, (idx < 30) ? 8'd200 : 8'd100, std_pix(idx), idx == 0, (idx % 10) == 0, 1'b1, 1'b0, 16'd0);
    wait_done("s5", sc, 8'd100, 0);
    expect_edges(tbl[0]);
    compare_votes("s5");

    // Reset during DRAIN with votes pending
    dut_q.delete();
    sc = done_cnt;
    tick(1'b1, 8'd200, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int idx = 0; idx < 100; idx++)
      tick(1'b0, 8'd200, std_pix(idx), idx == 0, (idx % 10) == 0, 1'b0, 1'b0, 16'd0);
    tick(1'b0, 8'd200, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check("s6_pre_busy", {30'd0, Busy, VoteValid}, 32'd3);
    #1 nReset = 1'b0;
    #1 check("s6_rst_outputs", {8'd0, VoteValid, Busy, FrameDone, Overflow, VoteTheta, VoteX, VoteY}, 32'd0);
    tick(1'b0, 8'd200, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    nReset = 1'b1;
    for (int c = 0; c < 12; c++) tick(1'b0, 8'd200, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    check("s6_no_done", done_cnt - sc, 32'd0);
    check("s6_no_votes", dut_q.size(), 32'd0);
    run_vec("s6_after", tbl[0]);

    // Randomized frames against the reference model
    for (int it = 0; it < 8; it++) begin
      logic [7:0] thr;
      int p, lim;
      bit resync, e;
      logic [7:0] pix;
      logic rdy;
      thr = 8'($urandom_range(120, 250));
      resync = (it % 3) == 1;
      dut_q.delete();
      model_reset();
      model_on = 1'b1;
      sc = done_cnt;
      tick(1'b1, thr, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
      for (int c = 0; c < int'($urandom_range(1, 6)); c++)
        tick(1'b0, thr, 8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 16'd0);
      p = 0;
      lim = resync ? 37 : 1000;
      while (p < 100) begin
        if (p == lim) begin p = 0; lim = 1000; end
        pix = 8'($urandom);
        rdy = ($urandom_range(0, 99) < 70);
        e = (pix >= thr);
        tick(1'b0, thr, pix, p == 0, (p % 10) == 0, rdy, e, {8'(p % 10), 8'(p / 10)});
        p++;
      end
      wait_done($sformatf("rnd%0d", it), sc, thr, 3);
      model_on = 1'b0;
      check($sformatf("rnd%0d_ovf", it), {31'd0, Overflow}, {31'd0, m_ovf});
      compare_votes($sformatf("rnd%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hough_vote_sched.md
Name: hough_vote_sched

Overview:
- Sits between the pixel-stream source and the Hough accumulator.
- Tracks the (col,row) position of each pixel from the Frame/Line strobes and thresholds each pixel to find edge pixels.
- Buffers edge coordinates in a small FIFO and issues one vote request per edge pixel per theta index over a valid/ready handshake.
- Captures exactly one frame per Start command, drains all pending votes, then pulses FrameDone.

Parameters:
- COLS, 10, pixels per line (max 256)
- ROWS, 10, lines per frame (max 256)
- NTHETA, 4, theta steps voted per edge pixel (2..2^THETA_W)
- THETA_W, 4, width of VoteTheta
- DEPTH, 4, edge-coordinate FIFO entries (power of two, >=2)

Ports:
- Clk  in  1  clock, rising edge
- nReset  in  1  asynchronous active-low reset
- Start  in  1  one-cycle pulse; arms capture of the next frame
- Threshold  in  8  edge threshold; sampled at Start, held internally
- Pixel  in  8  pixel value, one per clock
- Frame  in  1  high with the pixel at (0,0)
- Line  in  1  high with the pixel at column 0 of every row (also high with Frame)
- VoteValid  out  1  vote request valid
- VoteReady  in  1  accumulator accepts the vote
- VoteX  out  8  edge column
- VoteY  out  8  edge row
- VoteTheta  out  THETA_W  theta index
- Busy  out  1  high in any state other than IDLE
- FrameDone  out  1  one-cycle pulse after the last vote of a frame is accepted
- Overflow  out  1  sticky; an edge was dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock Clk; reset nReset is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0, stored threshold 0.
- Reset mid-operation: aborts immediately. The FIFO and the working vote are discarded, and no FrameDone is generated.
- States:
  - IDLE: wait for Start.
  - SYNC: discard pixels until Frame=1.
  - RUN: classify pixels.
  - DRAIN: no capture; wait for FIFO empty and emitter idle.
  - DONE: one cycle.
- Transitions:
  - IDLE -> SYNC on Start; latch Threshold and clear Overflow.
  - SYNC -> RUN on the cycle Frame=1. That pixel is (0,0) and is classified.
  - RUN -> DRAIN after classifying the pixel at (COLS-1, ROWS-1).
  - DRAIN -> DONE when FIFO empty and no vote is outstanding.
  - DONE -> IDLE. FrameDone=1 only in DONE.
- Start when not in IDLE is ignored.
- Position counters in RUN:
  - Frame sets col=0, row=0.
  - Otherwise Line sets col=0, row=row+1.
  - Otherwise col=col+1.
- Edge test: Pixel >= stored Threshold (unsigned). An edge pushes {col,row} into the FIFO.
- Full FIFO:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the edge is dropped and Overflow is set; Overflow holds until the next accepted Start.
- Emitter:
  - When idle and the FIFO is non-empty, pop the head into the working registers and set VoteTheta=0, VoteValid=1.
  - On VoteValid & VoteReady:
    - If VoteTheta < NTHETA-1, increment VoteTheta.
    - Otherwise: pop the next entry (theta=0, VoteValid stays 1) if the FIFO is non-empty; if empty, VoteValid=0.
- Handshake: while VoteValid=1 and VoteReady=0, VoteX, VoteY and VoteTheta are held stable. VoteValid never drops without acceptance, except on reset.
- Latency: with the emitter idle and FIFO empty, an edge pixel sampled at edge k gives VoteValid=1 after edge k+2. Back-to-back, one vote per clock while VoteReady=1.
- Each edge pixel yields exactly NTHETA votes, in theta order 0..NTHETA-1. Edge pixels are served in raster order.
- Frame asserted in RUN before the frame end resynchronises the counters to (0,0). Capture continues until (COLS-1, ROWS-1).

Test Plan:
1. Threshold=200, NTHETA=4, VoteReady=1, standard 10x10 test frame (values 202 at idx25, 208 at idx69) -> votes (5,2,0..3) then (9,6,0..3); exactly 8 votes; FrameDone once; Overflow=0.
2. Threshold=180, same frame -> edges in order (5,2),(6,3),(9,6),(6,8),(6,9); 20 votes total; pixel 178 (idx24) produces no vote.
3. DEPTH=2, Threshold=180, VoteReady=0 until after the frame -> (5,2) in the working registers, (6,3),(9,6) in the FIFO, (6,8),(6,9) dropped, Overflow=1. After VoteReady=1: 12 votes, then FrameDone.
4. Threshold=200, VoteReady toggling 1/0 every cycle -> VoteX/Y/Theta stable during stalls; same 8 votes as scenario 1.
5. Start pulsed mid-frame and again while in RUN -> capture begins at the next Frame; the second Start is ignored; one FrameDone.
6. nReset low during DRAIN with votes pending -> all outputs 0 immediately; no FrameDone. A subsequent Start behaves as in scenario 1.
